par_serial_tx: RTL and testbench
================================

Name: par_serial_tx

Overview:
- Downstream neighbour of the 2:1 byte merger in phy_tx: takes the merged byte stream (data + valid) and serializes it MSB-first onto a single-bit line.
- Uses a small input FIFO and a valid/ready handshake.
- Inserts the comma/idle character (K-symbol) into any symbol slot that has no data, so the line never stalls.
- Inputs are synchronous to clk_16f; the upstream clk_2f domain is derived synchronously from it.

Parameters:
- IDLE_CHAR, 8'hBC, symbol transmitted in empty slots (flagged as K).
- FIFO_DEPTH, 4, input buffer depth in bytes; power of two, ≥ 2.

Ports:
- clk_16f  input  1  bit-rate clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 = reset.
- data_in  input  8  byte from upstream merger.
- valid_in  input  1  data_in valid this cycle.
- ready_out  output  1  FIFO can accept a byte this cycle.
- data_out  output  1  serial bit, MSB of each symbol first.
- k_out  output  1  1 while the current symbol is IDLE_CHAR inserted by this block.
- sym_start  output  1  1 during the first bit (MSB) of every symbol.
- overflow  output  1  sticky: a byte was presented while ready_out = 0.

Behaviour:
- Reset and reset values:
  - Reset is synchronous, active-low, on clk_16f rising edge.
  - On reset: data_out = 0, k_out = 0, sym_start = 0, ready_out = 0, overflow = 0.
  - Internal state on reset: FIFO count and pointers = 0, bit_cnt = 0, shift register = 0.
  - Reset asserted mid-symbol aborts the symbol immediately; FIFO contents are discarded.
- Write side:
  - Push occurs on an edge where valid_in = 1 and ready_out = 1.
  - ready_out is registered: next value = (count_next < FIFO_DEPTH).
  - valid_in = 1 with ready_out = 0: byte dropped, overflow set to 1 and held until reset.
- Slot timing: bit_cnt is a 3-bit counter, 0..7, wrapping 7→0, running continuously out of reset.
- Load edge (bit_cnt = 0):
  - If count > 0: pop the FIFO head into the shift register; k_out <= 0.
  - Otherwise load IDLE_CHAR; k_out <= 1.
  - On the same edge: data_out <= symbol[7], sym_start <= 1, bit_cnt <= 1.
- Shift edges (bit_cnt = i, i = 1..7): data_out <= symbol[7-i], sym_start <= 0, bit_cnt <= i+1 mod 8.
- Symbol period: exactly 8 cycles.
  - First load edge is the first edge with reset = 1, so the first symbol after reset is IDLE_CHAR.
- Latency and ordering:
  - No bypass: a byte pushed on load edge L with an empty FIFO is sent in slot L+8, not L; slot L carries IDLE_CHAR.
  - Minimum latency from push to its MSB on data_out: 1 cycle if the next edge is a load edge, else up to 8 cycles.
- Simultaneous push and pop on one edge: count unchanged; byte order strictly FIFO.
- Full FIFO:
  - A pop on a load edge frees a slot; ready_out returns to 1 one edge later.
  - Pop does not combine with a same-edge push because ready_out was 0.
- Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, valid_in = 0 for 32 cycles -> four symbols 10111100, MSB first; k_out = 1 throughout; sym_start high on cycles 0, 8, 16, 24; ready_out = 1 from cycle 1.
- Single push of 8'hA5 at cycle 3 -> slot starting cycle 8 shows 10100101 with k_out = 0; slots 0 and 16 are IDLE_CHAR.
- Push of 8'h3C exactly on a load edge with empty FIFO -> that slot is IDLE_CHAR; 8'h3C is sent in the following slot (no bypass).
- Burst of 8'h01..8'h06 on consecutive cycles, valid_in held high:
  - ready_out falls after 4 accepted bytes.
  - Bytes 5 and 6 are dropped; overflow = 1 and stays 1.
  - Serial output is 01, 02, 03, 04 in order, then IDLE_CHAR.
- Steady stream, one push per 8 cycles aligned to 4 cycles before each load edge, over 64 cycles -> no IDLE_CHAR after the first data slot; overflow = 0.
- Reset asserted at bit 4 of a data symbol with 2 bytes queued -> next edge all outputs 0; after release only IDLE_CHAR is sent; the queued bytes never appear.

Source files
------------

// File: rtl/par_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : par_serial_tx
// Brief    : Byte FIFO plus MSB-first 8-bit symbol serializer; empty slots
//            carry IDLE_CHAR flagged as a K-symbol so the line never stalls.
// Revision : 1.0 - initial release
// ============================================================================
module par_serial_tx #(
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_16f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       k_out,
    output logic       sym_start,
    output logic       overflow
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;

    logic               w_push;
    logic               w_load;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic [7:0]         w_symbol;

    always_comb begin
        w_push       = valid_in && ready_out;
        w_load       = (r_bit_cnt == 3'd0);
        // Pop only sees bytes already stored, so a same-edge push never bypasses.
        w_pop        = w_load && (r_count != '0);
        w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        w_symbol     = w_pop ? r_mem[r_rd_ptr] : IDLE_CHAR;
    end

    always_ff @(posedge clk_16f) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_16f) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            data_out  <= 1'b0;
            k_out     <= 1'b0;
            sym_start <= 1'b0;
            ready_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_load) begin
                r_shift   <= {w_symbol[6:0], 1'b0};
                data_out  <= w_symbol[7];
                k_out     <= !w_pop;
                sym_start <= 1'b1;
            end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                data_out  <= r_shift[7];
                sym_start <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count   <= w_count_next;
            ready_out <= (w_count_next < c_CNT_W'(FIFO_DEPTH));
            overflow  <= overflow | (valid_in & ~ready_out);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_par_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_par_serial_tx
// Brief    : Self-checking bench for par_serial_tx against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par_serial_tx;

    localparam logic [7:0] c_IDLE  = 8'hBC;
    localparam int         c_DEPTH = 4;

    logic       clk_16f  = 1'b0;
    logic       reset    = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'd0;
    logic       ready_out;
    logic       data_out;
    logic       k_out;
    logic       sym_start;
    logic       overflow;

    par_serial_tx #(
        .IDLE_CHAR  (c_IDLE),
        .FIFO_DEPTH (c_DEPTH)
    ) u_dut (
        .clk_16f   (clk_16f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .k_out     (k_out),
        .sym_start (sym_start),
        .overflow  (overflow)
    );

    always #5 clk_16f = ~clk_16f;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a byte queue and a slot phase.
    logic [7:0] q[$];
    logic       m_ready, m_ovf, m_k, m_data, m_start;
    logic [7:0] m_sym;
    int         m_phase;

    task automatic model_reset();
        q.delete();
        m_ready = 0; m_ovf = 0; m_k = 0; m_data = 0; m_start = 0;
        m_sym = 8'd0; m_phase = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic push;
        push = v && m_ready;
        if (v && !m_ready) m_ovf = 1;
        if (m_phase == 0) begin
            if (q.size() > 0) begin
                m_sym = q.pop_front();
                m_k   = 0;
            end else begin
                m_sym = c_IDLE;
                m_k   = 1;
            end
        end
        m_data  = m_sym[7 - m_phase];
        m_start = (m_phase == 0);
        if (push) q.push_back(d);
        m_ready = (q.size() < c_DEPTH);
        m_phase = (m_phase + 1) % 8;
    endtask

    // Reassembles whole symbols from the serial line, keyed on sym_start.
    int         tr_cnt = 0;
    logic [7:0] tr_byte;
    logic       tr_k;
    logic [8:0] sym_log[$];

    task automatic observe();
        if (sym_start) begin
            tr_byte = {7'd0, data_out};
            tr_k    = k_out;
            tr_cnt  = 1;
        end else if (tr_cnt > 0) begin
            tr_byte = {tr_byte[6:0], data_out};
            tr_cnt++;
            if (tr_cnt == 8) begin
                sym_log.push_back({tr_k, tr_byte});
                tr_cnt = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        reset = 1; valid_in = v; data_in = d;
        @(posedge clk_16f);
        model_edge(v, d);
        #1;
        check_eq("outs", {27'd0, ready_out, overflow, k_out, sym_start, data_out},
                         {27'd0, m_ready, m_ovf, m_k, m_start, m_data});
        observe();
    endtask

    task automatic rst_cycle(input logic v, input logic [7:0] d);
        reset = 0; valid_in = v; data_in = d;
        @(posedge clk_16f);
        model_reset();
        #1;
        check_eq("rst_outs", {27'd0, ready_out, overflow, k_out, sym_start, data_out}, 32'd0);
        tr_cnt = 0;
    endtask

    task automatic expect_log(input string tag, input int i, input logic [8:0] exp);
        logic [31:0] obs;
        if (i < sym_log.size()) obs = {23'd0, sym_log[i]};
        else                    obs = 32'hDEAD_BEEF;
        check_eq(tag, obs, {23'd0, exp});
    endtask

    logic [7:0] stream[$];
    logic [7:0] b;
    int         dens;

    initial begin
        model_reset();
        rst_cycle(0, 8'h00);
        rst_cycle(1, 8'hFF);
        rst_cycle(0, 8'h00);

        // Idle line after reset
        sym_log.delete();
        repeat (32) cycle(0, 8'h00);
        check_eq("idle_count", sym_log.size(), 4);
        for (int i = 0; i < 4; i++) expect_log("idle_sym", i, {1'b1, c_IDLE});

        // Single push mid-slot
        sym_log.delete();
        repeat (3) cycle(0, 8'h00);
        cycle(1, 8'hA5);
        repeat (20) cycle(0, 8'h00);
        check_eq("single_count", sym_log.size(), 3);
        expect_log("single_s0", 0, {1'b1, c_IDLE});
        expect_log("single_s1", 1, {1'b0, 8'hA5});
        expect_log("single_s2", 2, {1'b1, c_IDLE});

        // Push exactly on a load edge: no bypass
        sym_log.delete();
        cycle(1, 8'h3C);
        repeat (15) cycle(0, 8'h00);
        expect_log("nobypass_s0", 0, {1'b1, c_IDLE});
        expect_log("nobypass_s1", 1, {1'b0, 8'h3C});

        // Burst that overruns the FIFO
        sym_log.delete();
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i));
        check_eq("burst_ready", {31'd0, ready_out}, 32'd0);
        cycle(1, 8'h05);
        cycle(1, 8'h06);
        repeat (42) cycle(0, 8'h00);
        check_eq("burst_count", sym_log.size(), 6);
        expect_log("burst_s0", 0, {1'b1, c_IDLE});
        for (int i = 1; i <= 4; i++) expect_log("burst_data", i, {1'b0, 8'(i)});
        expect_log("burst_s5", 5, {1'b1, c_IDLE});
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Steady stream, one push 4 cycles before each load edge
        rst_cycle(0, 8'h00);
        sym_log.delete();
        stream.delete();
        for (int s = 0; s < 9; s++) begin
            for (int ph = 0; ph < 8; ph++) begin
                if (s < 8 && ph == 4) begin
                    b = 8'($urandom);
                    stream.push_back(b);
                    cycle(1, b);
                end else begin
                    cycle(0, 8'h00);
                end
            end
        end
        check_eq("stream_count", sym_log.size(), 9);
        expect_log("stream_s0", 0, {1'b1, c_IDLE});
        for (int i = 1; i <= 8; i++) expect_log("stream_data", i, {1'b0, stream[i-1]});
        check_eq("stream_ovf", {31'd0, overflow}, 32'd0);

        // Reset at bit 4 of a data symbol with two bytes still queued
        sym_log.delete();
        cycle(1, 8'h11);
        cycle(1, 8'h22);
        cycle(1, 8'h33);
        repeat (9) cycle(0, 8'h00);
        rst_cycle(0, 8'h00);
        sym_log.delete();
        repeat (24) cycle(0, 8'h00);
        check_eq("postrst_count", sym_log.size(), 3);
        for (int i = 0; i < 3; i++) expect_log("postrst_sym", i, {1'b1, c_IDLE});

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            dens = (n < 300) ? 15 : 60;
            if ($urandom_range(0, 99) == 0) rst_cycle(1'($urandom), 8'($urandom));
            else cycle($urandom_range(0, 99) < dens, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
